// File: rtl/mips_dmem_map_ctrl.sv
// -----------------------------------------------------------------------------
// mips_dmem_map_ctrl
//
// Data-side memory map controller for a small MIPS core. The controller takes
// one CPU load/store at a time and decodes its byte address into one of three
// regions:
//   DATA  : 0x10010000 .. 0x10010000 + DMEM_BYTES/2 - 1  (lower RAM half)
//   STACK : SB .. 0x7fffefff, SB = 0x7ffff000 - DMEM_BYTES/2 (upper RAM half)
//   MMIO  : 0xffff0000 .. 0xffff0000 + MMIO_BYTES - 1
// Anything else, or any address that is not word aligned, faults. The fault
// response comes back without touching either memory port.
//
// Parameters:
//   DMEM_BYTES   - data RAM size in bytes (power of two, at least 16)
//   MMIO_BYTES   - MMIO window size in bytes (power of two, at most 64 KiB)
//   MMIO_TIMEOUT - MMIO cycles without ack before the access faults
//
// Optional feature (compile-time macro):
//   MIPS_DMEM_MMIO_TIMEOUT_EN - when defined, an MMIO access that sees no
//                               mmio_ack for MMIO_TIMEOUT cycles ends with a
//                               fault response. When undefined, MMIO accesses
//                               wait for mmio_ack indefinitely.
//
// Ports:
//   clk, rst_n                 - rising-edge clock, synchronous active-low reset
//   req_valid/we/addr/wdata    - CPU request; accepted when req_ready is high
//   req_ready                  - high only while idle
//   rsp_valid/rdata/fault      - one-cycle response pulse
//   dmem_en/we/addr/wdata      - data RAM port (word index); dmem_rdata is
//                                valid one cycle after dmem_en
//   mmio_en/we/addr/wdata      - MMIO port (byte offset), held until mmio_ack
//   mmio_rdata, mmio_ack       - MMIO read data and access completion
//
// Latency from the acceptance edge T to rsp_valid: fault T+1, RAM T+3,
// MMIO T+1 after the edge that samples mmio_ack.
// -----------------------------------------------------------------------------
module mips_dmem_map_ctrl #(
   parameter int unsigned DMEM_BYTES   = 1024,
   parameter int unsigned MMIO_BYTES   = 64,
   parameter int unsigned MMIO_TIMEOUT = 15
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            req_valid,
   input  logic                            req_we,
   input  logic [31:0]                     req_addr,
   input  logic [31:0]                     req_wdata,
   output logic                            req_ready,
   output logic                            rsp_valid,
   output logic [31:0]                     rsp_rdata,
   output logic                            rsp_fault,
   output logic                            dmem_en,
   output logic                            dmem_we,
   output logic [$clog2(DMEM_BYTES/4)-1:0] dmem_addr,
   output logic [31:0]                     dmem_wdata,
   input  logic [31:0]                     dmem_rdata,
   output logic                            mmio_en,
   output logic                            mmio_we,
   output logic [$clog2(MMIO_BYTES)-1:0]   mmio_addr,
   output logic [31:0]                     mmio_wdata,
   input  logic [31:0]                     mmio_rdata,
   input  logic                            mmio_ack
);

   localparam int unsigned AW = $clog2(DMEM_BYTES / 4);  // RAM word-index width
   localparam int unsigned MW = $clog2(MMIO_BYTES);      // MMIO offset width

   localparam logic [31:0] DATA_BASE  = 32'h1001_0000;
   localparam logic [31:0] STACK_BASE = 32'h7fff_f000 - 32'(DMEM_BYTES / 2);
   localparam logic [31:0] MMIO_BASE  = 32'hffff_0000;

   typedef enum logic [2:0] {
      IDLE,
      DMEM,
      DWAIT,
      MMIO,
      RSP
   } state_t;

   state_t state_q, state_d;

   // ---------------------------------------------------------------------------
   // Address decode. Offsets are taken in words; a region of DMEM_BYTES/2 bytes
   // is 2**(AW-1) words, so a hit is "all offset bits above AW-2 are zero" and
   // the low AW-1 bits are the word index inside that half of the RAM.
   // ---------------------------------------------------------------------------
   logic [29:0]   data_off;
   logic [29:0]   stack_off;
   logic          hit_data;
   logic          hit_stack;
   logic          hit_mmio;
   logic          dec_fault;
   logic [AW-1:0] dec_idx;

   // NOTE: every signal driven in an always_comb gets a default at the top;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      data_off  = req_addr[31:2] - DATA_BASE[31:2];
      stack_off = req_addr[31:2] - STACK_BASE[31:2];
      hit_data  = (data_off[29:AW-1] == '0);
      hit_stack = (stack_off[29:AW-1] == '0);
      hit_mmio  = (req_addr[31:MW] == MMIO_BASE[31:MW]);
      dec_fault = !(hit_data || hit_stack || hit_mmio) || (req_addr[1:0] != 2'b00);
      // Stack half sits above the data half in the RAM.
      dec_idx   = hit_stack ? {1'b1, stack_off[AW-2:0]} : {1'b0, data_off[AW-2:0]};
   end

   // ---------------------------------------------------------------------------
   // Optional MMIO timeout counter. timeout_hit is high in the last MMIO cycle
   // the controller is willing to wait; mmio_ack in that same cycle wins.
   // ---------------------------------------------------------------------------
   logic timeout_hit;

`ifdef MIPS_DMEM_MMIO_TIMEOUT_EN
   localparam int unsigned TW = $clog2(MMIO_TIMEOUT + 1);

   logic [TW-1:0] tmo_cnt_q;

   assign timeout_hit = (state_q == MMIO) && (tmo_cnt_q == TW'(MMIO_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
      end else if (state_q == MMIO && !mmio_ack && !timeout_hit) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
         tmo_cnt_q <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (dec_fault)     state_d = RSP;
               else if (hit_mmio) state_d = MMIO;
               else               state_d = DMEM;
            end
         end
         DMEM:    state_d = DWAIT;
         DWAIT:   state_d = RSP;
         MMIO: begin
            if (mmio_ack || timeout_hit) state_d = RSP;
         end
         RSP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // Request / response datapath
   // ---------------------------------------------------------------------------
   logic          we_q;
   logic [31:0]   wdata_q;
   logic [AW-1:0] idx_q;
   logic [MW-1:0] moff_q;
   logic          fault_q;
   logic [31:0]   rdata_q;

   // NOTE: the datapath registers have no reset; they are loaded on acceptance
   // and every output that shows them is gated by the (reset) state register.
   always_ff @(posedge clk) begin
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_q    <= req_we;
               wdata_q <= req_wdata;
               idx_q   <= dec_idx;
               moff_q  <= req_addr[MW-1:0];
               fault_q <= dec_fault;
               rdata_q <= '0;
            end
         end
         DWAIT: rdata_q <= we_q ? 32'h0 : dmem_rdata;
         MMIO: begin
            if (mmio_ack) begin
               rdata_q <= we_q ? 32'h0 : mmio_rdata;
            end else if (timeout_hit) begin
               fault_q <= 1'b1;
               rdata_q <= '0;
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs (Moore). req_ready is also held low while reset is asserted so no
   // output reads as active during reset.
   // ---------------------------------------------------------------------------
   assign req_ready  = (state_q == IDLE) && rst_n;

   assign rsp_valid  = (state_q == RSP);
   assign rsp_fault  = rsp_valid && fault_q;
   assign rsp_rdata  = (rsp_valid && !fault_q) ? rdata_q : 32'h0;

   assign dmem_en    = (state_q == DMEM);
   assign dmem_we    = dmem_en && we_q;
   assign dmem_addr  = dmem_en ? idx_q : '0;
   assign dmem_wdata = dmem_en ? wdata_q : 32'h0;

   assign mmio_en    = (state_q == MMIO);
   assign mmio_we    = mmio_en && we_q;
   assign mmio_addr  = mmio_en ? moff_q : '0;
   assign mmio_wdata = mmio_en ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mips_dmem_map_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_dmem_map_ctrl
//
// Directed bench for mips_dmem_map_ctrl with default parameters
// (DMEM_BYTES=1024, MMIO_BYTES=64, MMIO_TIMEOUT=15). A small behavioural RAM
// answers the data port; MMIO ack/rdata are driven directly by the stimulus.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mips_dmem_map_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        dmem_en;
   logic        dmem_we;
   logic [7:0]  dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        mmio_en;
   logic        mmio_we;
   logic [5:0]  mmio_addr;
   logic [31:0] mmio_wdata;
   logic [31:0] mmio_rdata;
   logic        mmio_ack;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mips_dmem_map_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_fault  (rsp_fault),
      .dmem_en    (dmem_en),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .mmio_en    (mmio_en),
      .mmio_we    (mmio_we),
      .mmio_addr  (mmio_addr),
      .mmio_wdata (mmio_wdata),
      .mmio_rdata (mmio_rdata),
      .mmio_ack   (mmio_ack)
   );

   // Behavioural data RAM: synchronous write, registered read.
   logic [31:0] ram [256];
   always @(posedge clk) begin
      if (dmem_en) begin
         if (dmem_we) ram[dmem_addr] <= dmem_wdata;
         dmem_rdata <= ram[dmem_addr];
      end
   end

   // Global time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of run, required finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present a request at the falling edge, let the next rising edge accept
   // it, then drop req_valid. Returns at the falling edge after acceptance.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      check("issue.req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic dmem_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [7:0] idx,
                              input logic [31:0] exp_rdata);
      issue(we, addr, wdata);
      check({tag, ".dmem_en"},   32'(dmem_en),   32'd1);
      check({tag, ".dmem_we"},   32'(dmem_we),   32'(we));
      check({tag, ".dmem_addr"}, 32'(dmem_addr), 32'(idx));
      if (we) check({tag, ".dmem_wdata"}, dmem_wdata, wdata);
      check({tag, ".early_rsp"}, 32'(rsp_valid), 32'd0);
      tick();
      check({tag, ".en_one_cycle"}, 32'(dmem_en), 32'd0);
      check({tag, ".t2_rsp"},       32'(rsp_valid), 32'd0);
      tick();
      check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".rsp_fault"}, 32'(rsp_fault), 32'd0);
      check({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
      tick();
      check({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, ".rdata_idle"}, rsp_rdata, 32'h0);
      check({tag, ".ready"},     32'(req_ready), 32'd1);
   endtask

   task automatic fault_access(input string tag, input logic [31:0] addr);
      issue(1'b0, addr, 32'h0);
      check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".rsp_fault"}, 32'(rsp_fault), 32'd1);
      check({tag, ".rsp_rdata"}, rsp_rdata, 32'h0);
      check({tag, ".dmem_en"},   32'(dmem_en), 32'd0);
      check({tag, ".mmio_en"},   32'(mmio_en), 32'd0);
      tick();
      check({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, ".ready"},     32'(req_ready), 32'd1);
   endtask

   // MMIO access: wait_cycles cycles without ack, then ack with ack_rdata.
   task automatic mmio_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [5:0] off,
                              input int wait_cycles, input logic [31:0] ack_rdata,
                              input logic [31:0] exp_rdata);
      issue(we, addr, wdata);
      for (int i = 0; i < wait_cycles; i++) begin
         check({tag, ".mmio_en"},   32'(mmio_en),   32'd1);
         check({tag, ".mmio_addr"}, 32'(mmio_addr), 32'(off));
         check({tag, ".mmio_we"},   32'(mmio_we),   32'(we));
         check({tag, ".no_rsp"},    32'(rsp_valid), 32'd0);
         tick();
      end
      check({tag, ".mmio_en_ack"},   32'(mmio_en),   32'd1);
      check({tag, ".mmio_addr_ack"}, 32'(mmio_addr), 32'(off));
      if (we) check({tag, ".mmio_wdata"}, mmio_wdata, wdata);
      mmio_ack   = 1'b1;
      mmio_rdata = ack_rdata;
      tick();
      mmio_ack   = 1'b0;
      mmio_rdata = 32'h0;
      check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".rsp_fault"}, 32'(rsp_fault), 32'd0);
      check({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
      check({tag, ".en_drop"},   32'(mmio_en), 32'd0);
      tick();
      check({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
   endtask

   logic [31:0] fault_addrs [7];
   logic        saw_rsp;

   initial begin
      fault_addrs = '{32'h0040_0000, 32'h1001_0002, 32'h7fff_f000, 32'h1001_0200,
                      32'h7fff_edfc, 32'hffff_0040, 32'hffff_0001};

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mmio_rdata = 32'h0;
      mmio_ack   = 1'b0;

      // ---- Reset state ------------------------------------------------------
      tick();
      tick();
      check("rst.req_ready", 32'(req_ready), 32'd0);
      check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst.dmem_en",   32'(dmem_en),   32'd0);
      check("rst.mmio_en",   32'(mmio_en),   32'd0);
      check("rst.rsp_rdata", rsp_rdata,      32'h0);
      rst_n = 1'b1;
      tick();
      check("rst.release_ready", 32'(req_ready), 32'd1);

      // ---- Data RAM: .data and stack halves, boundary indices ---------------
      dmem_access("st_data4",  1'b1, 32'h1001_0004, 32'hdead_beef, 8'd1,   32'h0);
      dmem_access("ld_data4",  1'b0, 32'h1001_0004, 32'h0,         8'd1,   32'hdead_beef);
      dmem_access("st_data_top", 1'b1, 32'h1001_01fc, 32'h1111_2222, 8'd127, 32'h0);
      dmem_access("st_sb",     1'b1, 32'h7fff_ee00, 32'h3333_4444, 8'd128, 32'h0);
      dmem_access("st_stk_top", 1'b1, 32'h7fff_effc, 32'h5555_6666, 8'd255, 32'h0);
      dmem_access("ld_stk_top", 1'b0, 32'h7fff_effc, 32'h0,        8'd255, 32'h5555_6666);
      dmem_access("ld_sb",     1'b0, 32'h7fff_ee00, 32'h0,         8'd128, 32'h3333_4444);
      dmem_access("ld_data_top", 1'b0, 32'h1001_01fc, 32'h0,       8'd127, 32'h1111_2222);

      // ---- Faults: unmapped and misaligned ----------------------------------
      for (int i = 0; i < 7; i++) begin
         fault_access($sformatf("fault%0d", i), fault_addrs[i]);
      end

      // ---- MMIO -------------------------------------------------------------
      mmio_access("mmio_ld8",  1'b0, 32'hffff_0008, 32'h0,         6'd8,  3, 32'h0000_005a, 32'h0000_005a);
      mmio_access("mmio_st16", 1'b1, 32'hffff_0010, 32'h0000_1234, 6'd16, 0, 32'hffff_ffff, 32'h0);

      // Stray ack in IDLE is ignored.
      mmio_ack = 1'b1;
      tick();
      check("stray_ack.rsp_valid", 32'(rsp_valid), 32'd0);
      check("stray_ack.ready",     32'(req_ready), 32'd1);
      mmio_ack = 1'b0;

      // ---- Reset during DWAIT -----------------------------------------------
      issue(1'b0, 32'h1001_0004, 32'h0);
      tick();
      rst_n = 1'b0;
      tick();
      check("rst_dwait.rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_dwait.dmem_en",   32'(dmem_en),   32'd0);
      check("rst_dwait.ready",     32'(req_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      check("rst_dwait.no_rsp",    32'(rsp_valid), 32'd0);
      check("rst_dwait.ready_rel", 32'(req_ready), 32'd1);

      // ---- Reset during MMIO (after 10 waiting cycles) ----------------------
      issue(1'b0, 32'hffff_0004, 32'h0);
      for (int i = 0; i < 9; i++) tick();
      check("rst_mmio.mmio_en_pre", 32'(mmio_en), 32'd1);
      rst_n = 1'b0;
      tick();
      check("rst_mmio.mmio_en",   32'(mmio_en),   32'd0);
      check("rst_mmio.mmio_addr", 32'(mmio_addr), 32'd0);
      check("rst_mmio.ready",     32'(req_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      check("rst_mmio.no_rsp",    32'(rsp_valid), 32'd0);
      check("rst_mmio.ready_rel", 32'(req_ready), 32'd1);

`ifdef MIPS_DMEM_MMIO_TIMEOUT_EN
      // ---- Timeout: 15 MMIO cycles, then fault ------------------------------
      issue(1'b0, 32'hffff_000c, 32'h0);
      saw_rsp = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (rsp_valid || !mmio_en) saw_rsp = 1'b1;
         tick();
      end
      check("tmo.wait_15", 32'(saw_rsp || !mmio_en), 32'd0);
      tick();
      check("tmo.rsp_valid", 32'(rsp_valid), 32'd1);
      check("tmo.rsp_fault", 32'(rsp_fault), 32'd1);
      check("tmo.rsp_rdata", rsp_rdata,      32'h0);
      check("tmo.mmio_en",   32'(mmio_en),   32'd0);
      tick();

      // Ack in the timeout cycle wins.
      mmio_access("tmo_ack", 1'b0, 32'hffff_0020, 32'h0, 6'd32, 14, 32'h0000_0077, 32'h0000_0077);
`else
      // ---- No timeout: wait well past 15 cycles, then ack -------------------
      issue(1'b0, 32'hffff_000c, 32'h0);
      saw_rsp = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (rsp_valid || !mmio_en) saw_rsp = 1'b1;
         tick();
      end
      check("no_tmo.waiting", 32'(saw_rsp), 32'd0);
      mmio_ack   = 1'b1;
      mmio_rdata = 32'h0000_00a5;
      tick();
      mmio_ack   = 1'b0;
      mmio_rdata = 32'h0;
      check("no_tmo.rsp_valid", 32'(rsp_valid), 32'd1);
      check("no_tmo.rsp_fault", 32'(rsp_fault), 32'd0);
      check("no_tmo.rsp_rdata", rsp_rdata,      32'h0000_00a5);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
